polara_switch_bank_ctrl: RTL and testbench

Time-multiplexed debounce controller for the bank of configuration switches on the Polara loopback chipset. It replaces per-switch free-running debounce counters with one shared sample-tick timer and small per-channel stability counters. It also provides a round-robin scheduler that reports debounced state changes as a valid/ready event stream to the chipset configuration logic, and keeps sticky overrun flags for changes that could not be reported.

---
 rtl/polara_switch_bank_ctrl.sv | 150 +++++++++++++++
 tb/tb_polara_switch_bank_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/polara_switch_bank_ctrl.sv
// Shared-tick debounce controller for the Polara configuration switch bank.
// Debounced changes are reported round-robin as a valid/ready event stream.
module polara_switch_bank_ctrl #(
  parameter int              N_SW      = 8,
  parameter int              N_TICK    = 14,
  parameter int              N_STABLE  = 4,
  parameter logic [N_SW-1:0] IS_PULLUP = '0,
  localparam int             ID_W      = (N_SW > 1) ? $clog2(N_SW) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_SW-1:0] i_sw,
  input  logic            enable,
  output logic [N_SW-1:0] o_sw_deb,
  output logic            o_tick,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [ID_W-1:0] evt_id,
  output logic            evt_level,
  output logic [N_SW-1:0] o_overrun,
  input  logic            ovr_clr
);

  localparam logic [3:0] CNT_MAX = 4'(N_STABLE - 1);

  typedef enum logic {S_IDLE, S_PRESENT} state_t;

  logic [N_SW-1:0]   r_sync_p0, r_sync_p1;
  logic [N_SW-1:0]   r_cand, r_deb, r_pending, r_overrun;
  logic [3:0]        r_cnt [N_SW];
  logic [N_TICK-1:0] r_tick_cnt;
  logic [ID_W-1:0]   r_rr;
  state_t            r_state;

  logic              w_tick;
  logic [N_SW-1:0]   w_cand_nxt, w_deb_nxt, w_set, w_clr, w_ovr_set;
  logic [3:0]        w_cnt_nxt [N_SW];
  logic              w_grant_vld;
  logic [ID_W-1:0]   w_grant, w_idx;

  assign w_tick    = enable && (r_tick_cnt == '1);
  assign o_tick    = w_tick;
  assign o_sw_deb  = r_deb;
  assign o_overrun = r_overrun;

  // Stage p0/p1: two-flop synchroniser on the raw switch inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_p0 <= IS_PULLUP;
      r_sync_p1 <= IS_PULLUP;
    end else begin
      r_sync_p0 <= i_sw;
      r_sync_p1 <= r_sync_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !enable) r_tick_cnt <= '0;
    else                r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  // A new candidate restarts its count; acceptance needs a full stable run
  always_comb begin
    w_cand_nxt = r_cand;
    w_deb_nxt  = r_deb;
    w_set      = '0;
    for (int i = 0; i < N_SW; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (w_tick) begin
        if (r_sync_p1[i] != r_cand[i]) begin
          w_cand_nxt[i] = r_sync_p1[i];
          w_cnt_nxt[i]  = '0;
        end else if (r_cnt[i] == CNT_MAX && r_cand[i] != r_deb[i]) begin
          w_deb_nxt[i] = r_cand[i];
          w_set[i]     = 1'b1;
        end else if (r_cnt[i] != CNT_MAX) begin
          w_cnt_nxt[i] = r_cnt[i] + 4'd1;
        end
      end
    end
  end

  // Search downward so the channel right after r_rr is assigned last and wins
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant     = '0;
    w_idx       = '0;
    for (int k = N_SW; k >= 1; k--) begin
      w_idx = ID_W'((int'(r_rr) + k) % N_SW);
      if (r_pending[w_idx]) begin
        w_grant_vld = 1'b1;
        w_grant     = w_idx;
      end
    end
  end

  always_comb begin
    w_clr = '0;
    if (r_state == S_IDLE && w_grant_vld) w_clr[w_grant] = 1'b1;
  end

  assign w_ovr_set = w_set & r_pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cand    <= IS_PULLUP;
      r_deb     <= IS_PULLUP;
      r_pending <= '0;
      r_overrun <= '0;
      for (int i = 0; i < N_SW; i++) r_cnt[i] <= '0;
    end else begin
      r_cand    <= w_cand_nxt;
      r_deb     <= w_deb_nxt;
      r_pending <= (r_pending & ~w_clr) | w_set;
      r_overrun <= (ovr_clr ? '0 : r_overrun) | w_ovr_set;
      for (int i = 0; i < N_SW; i++) r_cnt[i] <= w_cnt_nxt[i];
    end
  end

  // Event scheduler: IDLE grants and latches, PRESENT holds until accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rr      <= '0;
      evt_valid <= 1'b0;
      evt_id    <= '0;
      evt_level <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_vld) begin
            evt_id    <= w_grant;
            evt_level <= w_deb_nxt[w_grant];
            r_rr      <= w_grant;
            evt_valid <= 1'b1;
            r_state   <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (evt_ready) begin
            evt_valid <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_polara_switch_bank_ctrl.sv
// Directed bench for polara_switch_bank_ctrl: N_SW=4, N_TICK=2, N_STABLE=3,
// IS_PULLUP=4'b1000. Inputs are driven and outputs sampled on the falling edge.
module tb_polara_switch_bank_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] i_sw;
  logic       enable;
  logic [3:0] o_sw_deb;
  logic       o_tick;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_id;
  logic       evt_level;
  logic [3:0] o_overrun;
  logic       ovr_clr;

  int n_cmp  = 0;
  int n_fail = 0;

  polara_switch_bank_ctrl #(
    .N_SW(4), .N_TICK(2), .N_STABLE(3), .IS_PULLUP(4'b1000)
  ) dut (
    .clk(clk), .rst(rst), .i_sw(i_sw), .enable(enable),
    .o_sw_deb(o_sw_deb), .o_tick(o_tick),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_id(evt_id), .evt_level(evt_level),
    .o_overrun(o_overrun), .ovr_clr(ovr_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick();
    logic got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = o_tick;
    end
    check("tick_wait", {31'd0, got}, 32'd1);
  endtask

  task automatic wait_valid(input string tag);
    logic got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = evt_valid;
    end
    check(tag, {31'd0, got}, 32'd1);
  endtask

  task automatic wait_deb1(input logic val);
    logic got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = (o_sw_deb[1] === val);
    end
    check("deb1_wait", {31'd0, got}, 32'd1);
  endtask

  task automatic accept_evt();
    evt_ready = 1'b1;
    cyc(1);
    evt_ready = 1'b0;
  endtask

  initial begin
    logic stable;
    rst = 1'b1; i_sw = 4'b1000; enable = 1'b1; evt_ready = 1'b0; ovr_clr = 1'b0;
    cyc(3);
    check("rst_deb", o_sw_deb, 4'b1000);
    check("rst_valid", evt_valid, 1'b0);
    check("rst_ovr", o_overrun, 4'b0000);
    check("rst_tick", o_tick, 1'b0);
    check("rst_id", evt_id, 2'd0);
    rst = 1'b0;

    // tick period: counter 1,2,3 -> pulse, then every 4 cycles
    cyc(3); check("tick_first", o_tick, 1'b1);
    cyc(1); check("tick_low", o_tick, 1'b0);
    cyc(3); check("tick_second", o_tick, 1'b1);

    // ch0 rises: first tick seeing sync is 4 cycles later, accept 3 ticks after
    wait_tick();
    i_sw = 4'b1001;
    cyc(16); check("deb_before_accept", o_sw_deb, 4'b1000);
    cyc(1);  check("deb_at_accept", o_sw_deb, 4'b1001);
    check("valid_at_accept", evt_valid, 1'b0);
    cyc(1);  check("ev0_valid", evt_valid, 1'b1);
    check("ev0_id", evt_id, 2'd0);
    check("ev0_level", evt_level, 1'b1);
    accept_evt();
    check("ev0_drop", evt_valid, 1'b0);

    // 6-cycle glitch on ch1 spans fewer than 3 ticks
    wait_tick();
    i_sw = 4'b1011;
    cyc(6);
    i_sw = 4'b1001;
    cyc(30);
    check("glitch_deb", o_sw_deb, 4'b1001);
    check("glitch_valid", evt_valid, 1'b0);

    // release ch3 so the round-robin pointer sits at 3
    i_sw = 4'b0001;
    wait_valid("ev3_wait");
    check("ev3_id", evt_id, 2'd3);
    check("ev3_level", evt_level, 1'b0);
    accept_evt();

    // ch0 and ch2 change together; ch0 is next after 3
    i_sw = 4'b0100;
    wait_valid("evA_wait");
    check("evA_id", evt_id, 2'd0);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      stable &= (evt_valid === 1'b1) && (evt_id === 2'd0) && (evt_level === 1'b0);
    end
    check("evA_hold_stable", stable, 1'b1);
    accept_evt();
    check("evA_drop", evt_valid, 1'b0);
    cyc(1);
    check("evB_valid", evt_valid, 1'b1);
    check("evB_id", evt_id, 2'd2);
    check("evB_level", evt_level, 1'b1);
    accept_evt();

    // next round: ch0 and ch3 together, pointer at 2 so ch3 goes first
    i_sw = 4'b1101;
    wait_valid("evC_wait");
    check("evC_id", evt_id, 2'd3);
    check("evC_level", evt_level, 1'b1);
    accept_evt();
    cyc(1);
    check("evD_valid", evt_valid, 1'b1);
    check("evD_id", evt_id, 2'd0);
    check("evD_level", evt_level, 1'b1);
    accept_evt();

    // hold a ch2 event unaccepted, then toggle ch1 twice
    i_sw = 4'b1001;
    wait_valid("evE_wait");
    check("evE_id", evt_id, 2'd2);
    i_sw = 4'b1011;
    wait_deb1(1'b1);
    check("ovr_after_first", o_overrun, 4'b0000);
    i_sw = 4'b1001;
    wait_deb1(1'b0);
    cyc(1);
    check("ovr_after_second", o_overrun, 4'b0010);
    check("evE_still_id", evt_id, 2'd2);
    accept_evt();
    cyc(1);
    check("evF_valid", evt_valid, 1'b1);
    check("evF_id", evt_id, 2'd1);
    check("evF_level", evt_level, o_sw_deb[1]);
    check("evF_level_val", evt_level, 1'b0);
    accept_evt();
    ovr_clr = 1'b1;
    cyc(1);
    ovr_clr = 1'b0;
    check("ovr_cleared", o_overrun, 4'b0000);

    // ch1 and ch2 rise together; ch2 presented, ch1 still queued
    i_sw = 4'b1111;
    wait_valid("evG_wait");
    check("evG_id", evt_id, 2'd2);
    enable = 1'b0;
    i_sw = 4'b1000;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      stable &= (o_tick === 1'b0) && (o_sw_deb === 4'b1111);
    end
    check("disabled_frozen", stable, 1'b1);
    accept_evt();
    cyc(1);
    check("drain_valid", evt_valid, 1'b1);
    check("drain_id", evt_id, 2'd1);
    check("drain_level", evt_level, 1'b1);

    // reset while an event is presented
    rst = 1'b1;
    cyc(1);
    check("mid_rst_valid", evt_valid, 1'b0);
    check("mid_rst_deb", o_sw_deb, 4'b1000);
    check("mid_rst_id", evt_id, 2'd0);
    rst = 1'b0;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
